// File: rtl/segint_pkg.sv
// Shared definitions for the segment integrator: state encoding, counter
// width helper and the default segment count of the display bitmap.
package segint_pkg;

    localparam int unsigned NB_SEGMENTS_DEF = 70;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DONE  = 2'd2;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int unsigned cw_of(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seg_counter.sv
// Per-segment lit counter with synchronous clear, increment enable and a
// look-ahead ">= threshold" flag computed from the post-update count.
module seg_counter #(
    parameter int unsigned CW        = 5,
    parameter int unsigned THRESHOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit_c
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt + CW'(inc);
        hit_c   = (cnt_nxt >= CW'(THRESHOLD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/segment_integrator.sv
// Integrates selected-segment frames over a capture window and thresholds the
// per-segment lit counts to recover the displayed message.
module segment_integrator
    import segint_pkg::*;
#(
    parameter int unsigned NB_SEGMENTS = NB_SEGMENTS_DEF,
    parameter int unsigned NB_FRAMES   = 16,
    parameter int unsigned THRESHOLD   = 4,
    parameter int unsigned CW          = cw_of(NB_FRAMES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   frm_valid,
    output logic                   frm_ready,
    input  logic [NB_SEGMENTS-1:0] frm_seg,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [NB_SEGMENTS-1:0] msg,
    output logic                   busy,
    output logic [CW-1:0]          frame_cnt
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   clr_c;
    logic                   acc_c;
    logic                   load_c;
    logic [NB_SEGMENTS-1:0] hit_c;

    // start wins over a simultaneous frame; DONE ignores start until consumed.
    always_comb begin
        state_nxt = state;
        clr_c     = 1'b0;
        acc_c     = 1'b0;
        load_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                    clr_c     = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    clr_c = 1'b1;
                end else if (frm_valid && frm_ready) begin
                    acc_c = 1'b1;
                    if (frame_cnt == CW'(NB_FRAMES - 1)) begin
                        state_nxt = DONE;
                        load_c    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (msg_valid && msg_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frm_ready <= 1'b0;
            msg_valid <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            msg       <= '0;
        end else begin
            state     <= state_nxt;
            frm_ready <= (state_nxt == ACCUM);
            busy      <= (state_nxt == ACCUM);
            msg_valid <= (state_nxt == DONE);
            if (clr_c) begin
                frame_cnt <= '0;
            end else if (acc_c) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
            if (load_c) begin
                msg <= hit_c;
            end
        end
    end

    for (genvar i = 0; i < NB_SEGMENTS; i++) begin : g_seg
        seg_counter #(
            .CW       (CW),
            .THRESHOLD(THRESHOLD)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr_c),
            .inc  (acc_c & frm_seg[i]),
            .hit_c(hit_c[i])
        );
    end

endmodule

// File: tb/tb_segment_integrator.sv
// Scoreboard bench for segment_integrator with 8 segments, 4 frames, threshold 2.
module tb_segment_integrator;

    localparam int unsigned NS = 8;
    localparam int unsigned NF = 4;
    localparam int unsigned TH = 2;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          frm_valid;
    logic          frm_ready;
    logic [NS-1:0] frm_seg;
    logic          msg_valid;
    logic          msg_ready;
    logic [NS-1:0] msg;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic [NS-1:0] sb_q[$];

    segment_integrator #(
        .NB_SEGMENTS(NS),
        .NB_FRAMES  (NF),
        .THRESHOLD  (TH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frm_valid(frm_valid),
        .frm_ready(frm_ready),
        .frm_seg  (frm_seg),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg      (msg),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected message whenever an output transfer is pending.
    always @(negedge clk) begin
        if (!rst && msg_valid && msg_ready) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_unexpected: got msg %0h want no message", msg);
            end else begin
                chk("sb_msg", 64'(msg), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_cnt", 64'(frame_cnt), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic send_frame(input logic [NS-1:0] v);
        frm_valid = 1'b1;
        frm_seg   = v;
        @(posedge clk);
        #1;
        frm_valid = 1'b0;
        frm_seg   = 'x;
    endtask

    // Sends a full window, checking frame_cnt after each accept and the
    // msg_valid latency after the last one.
    task automatic send4(input logic [NS-1:0] f0, input logic [NS-1:0] f1,
                         input logic [NS-1:0] f2, input logic [NS-1:0] f3);
        logic [NS-1:0] fr[4];
        fr = '{f0, f1, f2, f3};
        for (int i = 0; i < 4; i++) begin
            send_frame(fr[i]);
            chk("frame_cnt", 64'(frame_cnt), 64'(i + 1));
        end
        chk("done_valid", 64'(msg_valid), 64'd1);
        chk("done_ready", 64'(frm_ready), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
    endtask

    task automatic consume();
        msg_ready = 1'b1;
        @(posedge clk);
        #1;
        msg_ready = 1'b0;
        chk("consumed_valid", 64'(msg_valid), 64'd0);
        chk("consumed_ready", 64'(frm_ready), 64'd0);
    endtask

    task automatic window(input logic [NS-1:0] f0, input logic [NS-1:0] f1,
                          input logic [NS-1:0] f2, input logic [NS-1:0] f3,
                          input logic [NS-1:0] exp);
        do_start();
        sb_q.push_back(exp);
        send4(f0, f1, f2, f3);
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        frm_valid = 1'b0;
        frm_seg   = '0;
        msg_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then frm_valid in IDLE must not count.
        chk("rst_ready", 64'(frm_ready), 64'd0);
        chk("rst_valid", 64'(msg_valid), 64'd0);
        chk("rst_msg", 64'(msg), 64'd0);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        frm_valid = 1'b1;
        frm_seg   = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        frm_valid = 1'b0;
        chk("idle_cnt", 64'(frame_cnt), 64'd0);
        chk("idle_valid", 64'(msg_valid), 64'd0);
        chk("idle_ready", 64'(frm_ready), 64'd0);

        // Basic decode with backpressure; start and frames in DONE are ignored.
        do_start();
        sb_q.push_back(8'h01);
        send4(8'h03, 8'h01, 8'h81, 8'h00);
        for (int i = 0; i < 10; i++) begin
            start     = (i == 3);
            frm_valid = 1'b1;
            frm_seg   = 8'hFF;
            @(posedge clk);
            #1;
            chk("bp_msg", 64'(msg), 64'h01);
            chk("bp_valid", 64'(msg_valid), 64'd1);
            chk("bp_ready", 64'(frm_ready), 64'd0);
        end
        start     = 1'b0;
        frm_valid = 1'b0;
        chk("bp_cnt", 64'(frame_cnt), 64'd4);
        consume();
        chk("idle_keeps_msg", 64'(msg), 64'h01);

        // Threshold boundaries on segment 7 and a mixed pattern.
        window(8'h80, 8'h00, 8'h80, 8'h00, 8'h80);
        window(8'h00, 8'h00, 8'h00, 8'h80, 8'h00);
        window(8'h81, 8'h82, 8'h84, 8'h80, 8'h80);
        window(8'h0F, 8'h3C, 8'hF0, 8'h00, 8'h3C);

        // Restart priority: start drops the simultaneous frame.
        do_start();
        send_frame(8'hFF);
        send_frame(8'hFF);
        start     = 1'b1;
        frm_valid = 1'b1;
        frm_seg   = 8'hFF;
        @(posedge clk);
        #1;
        start     = 1'b0;
        frm_valid = 1'b0;
        chk("restart_cnt", 64'(frame_cnt), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        sb_q.push_back(8'h00);
        send4(8'h00, 8'h00, 8'h00, 8'h00);
        consume();

        // Asynchronous reset mid-window clears outputs before any clock edge.
        do_start();
        send_frame(8'hFF);
        send_frame(8'hFF);
        send_frame(8'hFF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 64'(frm_ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cnt", 64'(frame_cnt), 64'd0);
        chk("arst_valid", 64'(msg_valid), 64'd0);
        chk("arst_msg", 64'(msg), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        window(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
